// File: rtl/mul_div_unit.sv
// Multicycle signed multiply/divide engine: one bit per cycle on operand magnitudes,
// signs applied in a final fix-up cycle, HI/LO loaded only at the end of that cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clck,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, MUL, DIV, DZ, FIX, DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    logic               is_div, neg_res, neg_rem, dz_flag;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mag_b;
    // opa is the shifting multiplicand for MUL and the dividend/quotient register for DIV
    logic [2*WIDTH-1:0] opa;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH+1:0]   trial;
    logic               fits;
    logic               last;

    always_comb begin
        abs_a = a[WIDTH-1] ? -a : a;
        abs_b = b[WIDTH-1] ? -b : b;
        last  = (count == CW'(WIDTH - 1));
        // Both top bits clear means the trial subtraction did not borrow
        trial = {1'b0, rem, opa[WIDTH-1]} - {1'b0, mag_b};
        fits  = ~|trial[WIDTH+1:WIDTH];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_mult)
                    state_nx = MUL;
                else if (start_div)
                    state_nx = (b == '0) ? DZ : DIV;
            end
            MUL, DIV: if (last) state_nx = FIX;
            DZ:       state_nx = DONE;
            FIX:      state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == MUL) || (state == DIV) || (state == FIX) || (state == DZ);
        done     = (state == DONE);
        div_zero = (state == DONE) && dz_flag;
    end

    always_ff @(posedge clck) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_flag <= 1'b0;
            mag_b   <= '0;
            opa     <= '0;
            acc     <= '0;
            rem     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start_mult || start_div) begin
                        is_div  <= !start_mult;
                        neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem <= a[WIDTH-1];
                        dz_flag <= !start_mult && (b == '0);
                        mag_b   <= {1'b0, abs_b};
                        opa     <= {{WIDTH{1'b0}}, abs_a};
                        acc     <= '0;
                        rem     <= '0;
                        count   <= '0;
                    end
                end
                MUL: begin
                    if (mag_b[0])
                        acc <= acc + opa;
                    opa   <= opa << 1;
                    mag_b <= mag_b >> 1;
                    count <= count + CW'(1);
                end
                DIV: begin
                    rem   <= fits ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], opa[WIDTH-1]};
                    opa   <= {opa[2*WIDTH-2:0], fits};
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        lo <= neg_res ? -opa[WIDTH-1:0] : opa[WIDTH-1:0];
                        hi <= neg_rem ? -rem : rem;
                    end else begin
                        {hi, lo} <= neg_res ? -acc : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
